tx_burst_gen: RTL and testbench

//  Consumes the 1 kHz one-cycle trigger pulse from the trigger stage (150 MHz domain). Fires a fixed-length

---
 rtl/tx_burst_gen.sv | 171 +++++++++++++++++
 tb/tb_tx_burst_gen.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/tx_burst_gen.sv
// tx_burst_gen: ultrasonic transmit sequencer.
// On an accepted trigger it fires a complementary square-wave burst on tx_p/tx_n,
// waits a blanking gap, then opens a listen window for echo capture.
// Optional feature: define DEADTIME_EN to insert DEAD_CYC idle cycles at the
// start of every half-period (both legs low) without changing burst timing.
module tx_burst_gen #(
   parameter int HALF_PERIOD_CYC = 1875,
   parameter int NUM_CYCLES      = 8,
   parameter int BLANK_CYC       = 15000,
   parameter int LISTEN_CYC      = 100000,
   parameter int DEAD_CYC        = 94
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       trigger_in,
   input  logic       enable_in,
   output logic       tx_p,
   output logic       tx_n,
   output logic       tx_active,
   output logic       listen_window,
   output logic       listen_start,
   output logic       listen_done,
   output logic       busy,
   output logic [7:0] overrun_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BURST  = 2'd1,
      BLANK  = 2'd2,
      LISTEN = 2'd3
   } state_t;

   localparam int WIN_MAX = (BLANK_CYC > LISTEN_CYC) ? BLANK_CYC : LISTEN_CYC;
   localparam int PW      = $clog2(HALF_PERIOD_CYC);
   localparam int HW      = $clog2(2 * NUM_CYCLES);
   localparam int WW      = $clog2(WIN_MAX + 1);

   localparam logic [PW-1:0] PHASE_LAST  = PW'(HALF_PERIOD_CYC - 1);
   localparam logic [HW-1:0] HALF_LAST   = HW'(2 * NUM_CYCLES - 1);
   localparam logic [WW-1:0] BLANK_LAST  = WW'(BLANK_CYC - 1);
   localparam logic [WW-1:0] LISTEN_LAST = WW'(LISTEN_CYC - 1);

`ifdef DEADTIME_EN
   localparam int DEAD_EFF = DEAD_CYC;
`else
   // Without dead time the drive is active from the first cycle of each half-period.
   localparam int DEAD_EFF = DEAD_CYC * 0;
`endif

   state_t          state_q, state_d;
   logic [PW-1:0]   phase_q, phase_d;   // cycle within the current half-period
   logic [HW-1:0]   half_q,  half_d;    // half-period index; bit 0 selects the leg
   logic [WW-1:0]   win_q,   win_d;     // shared BLANK / LISTEN cycle counter
   logic [7:0]      overrun_q, overrun_d;

   logic            tx_p_q, tx_p_d;
   logic            tx_n_q, tx_n_d;
   logic            tx_active_q, tx_active_d;
   logic            listen_window_q, listen_window_d;
   logic            listen_start_q, listen_start_d;
   logic            listen_done_q, listen_done_d;
   logic            busy_q, busy_d;
   logic            in_dead;

   // Next-state, counter and registered-output decode.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
      state_d   = state_q;
      phase_d   = phase_q;
      half_d    = half_q;
      win_d     = win_q;
      overrun_d = overrun_q;

      case (state_q)
         IDLE: begin
            if (trigger_in && enable_in) begin
               state_d = BURST;
               phase_d = '0;
               half_d  = '0;
            end
         end
         BURST: begin
            if (phase_q == PHASE_LAST) begin
               phase_d = '0;
               if (half_q == HALF_LAST) begin
                  state_d = BLANK;
                  win_d   = '0;
               end else begin
                  half_d = half_q + HW'(1);
               end
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         BLANK: begin
            if (win_q == BLANK_LAST) begin
               state_d = LISTEN;
               win_d   = '0;
            end else begin
               win_d = win_q + WW'(1);
            end
         end
         LISTEN: begin
            if (win_q == LISTEN_LAST) begin
               state_d = IDLE;
            end else begin
               win_d = win_q + WW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // A trigger arriving in any non-idle state is dropped and counted.
      if (trigger_in && (state_q != IDLE) && (overrun_q != 8'hFF)) begin
         overrun_d = overrun_q + 8'd1;
      end

      // Outputs are decoded from the next state so they appear registered on the same edge.
      in_dead         = (int'(phase_d) < DEAD_EFF);
      tx_active_d     = (state_d == BURST);
      tx_p_d          = tx_active_d && !half_d[0] && !in_dead;
      tx_n_d          = tx_active_d &&  half_d[0] && !in_dead;
      listen_window_d = (state_d == LISTEN);
      listen_start_d  = listen_window_d && (state_q != LISTEN);
      listen_done_d   = listen_window_d && (win_d == LISTEN_LAST);
      busy_d          = (state_d != IDLE);
   end

   // State, counter and output registers with synchronous reset.
   always_ff @(posedge clk_in) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (rst_in) begin
         state_q         <= IDLE;
         phase_q         <= '0;
         half_q          <= '0;
         win_q           <= '0;
         overrun_q       <= '0;
         tx_p_q          <= 1'b0;
         tx_n_q          <= 1'b0;
         tx_active_q     <= 1'b0;
         listen_window_q <= 1'b0;
         listen_start_q  <= 1'b0;
         listen_done_q   <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         phase_q         <= phase_d;
         half_q          <= half_d;
         win_q           <= win_d;
         overrun_q       <= overrun_d;
         tx_p_q          <= tx_p_d;
         tx_n_q          <= tx_n_d;
         tx_active_q     <= tx_active_d;
         listen_window_q <= listen_window_d;
         listen_start_q  <= listen_start_d;
         listen_done_q   <= listen_done_d;
         busy_q          <= busy_d;
      end
   end

   assign tx_p          = tx_p_q;
   assign tx_n          = tx_n_q;
   assign tx_active     = tx_active_q;
   assign listen_window = listen_window_q;
   assign listen_start  = listen_start_q;
   assign listen_done   = listen_done_q;
   assign busy          = busy_q;
   assign overrun_cnt   = overrun_q;

endmodule

// File: tb/tb_tx_burst_gen.sv
// Bench for tx_burst_gen with small timing parameters. Each accepted trigger
// pushes the expected per-cycle output vectors of a full sequence onto a
// scoreboard queue; every clock one entry is popped and compared.
// Build with DEADTIME_EN defined to check the dead-time variant.
module tb_tx_burst_gen;

   localparam int HP  = 4;
   localparam int NC  = 3;
   localparam int BL  = 5;
   localparam int LI  = 10;
   localparam int DC  = 1;

   localparam int BURST_END  = 2 * NC * HP;         // 24
   localparam int BLANK_END  = BURST_END + BL;      // 29
   localparam int SEQ_LEN    = BLANK_END + LI;      // 39
`ifdef DEADTIME_EN
   localparam int DEAD_MODEL = DC;
`else
   localparam int DEAD_MODEL = 0;
`endif

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic       trigger_in = 1'b0;
   logic       enable_in = 1'b0;
   logic       tx_p, tx_n, tx_active, listen_window, listen_start, listen_done, busy;
   logic [7:0] overrun_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // bit order: {tx_p, tx_n, tx_active, listen_window, listen_start, listen_done, busy}
   logic [6:0] sb[$];
   int         exp_ovr  = 0;
   logic       cur_busy = 1'b0;

   tx_burst_gen #(
      .HALF_PERIOD_CYC(HP),
      .NUM_CYCLES     (NC),
      .BLANK_CYC      (BL),
      .LISTEN_CYC     (LI),
      .DEAD_CYC       (DC)
   ) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .trigger_in   (trigger_in),
      .enable_in    (enable_in),
      .tx_p         (tx_p),
      .tx_n         (tx_n),
      .tx_active    (tx_active),
      .listen_window(listen_window),
      .listen_start (listen_start),
      .listen_done  (listen_done),
      .busy         (busy),
      .overrun_cnt  (overrun_cnt)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected outputs k cycles after the cycle in which the trigger was sampled.
   function automatic logic [6:0] exp_at(input int k);
      logic [6:0] e;
      int h, ph;
      e = '0;
      if (k >= 1 && k <= BURST_END) begin
         h  = (k - 1) / HP;
         ph = (k - 1) % HP;
         e[4] = 1'b1;
         e[0] = 1'b1;
         if (ph >= DEAD_MODEL) begin
            if (h % 2 == 0) e[6] = 1'b1;
            else            e[5] = 1'b1;
         end
      end else if (k > BURST_END && k <= BLANK_END) begin
         e[0] = 1'b1;
      end else if (k > BLANK_END && k <= SEQ_LEN) begin
         e[3] = 1'b1;
         e[0] = 1'b1;
         e[2] = (k == BLANK_END + 1);
         e[1] = (k == SEQ_LEN);
      end
      return e;
   endfunction

   // Drive one cycle of inputs, update the model, then compare the following cycle.
   task automatic cyc(input logic trig, input logic en, input logic rst);
      logic [6:0] e;
      if (rst) begin
         sb.delete();
         exp_ovr = 0;
      end else if (trig) begin
         if (cur_busy) begin
            if (exp_ovr < 255) exp_ovr++;
         end else if (en) begin
            for (int k = 1; k <= SEQ_LEN; k++) sb.push_back(exp_at(k));
         end
      end
      trigger_in = trig;
      enable_in  = en;
      rst_in     = rst;
      @(posedge clk_in);
      #1;
      if (sb.size() > 0) e = sb.pop_front();
      else               e = '0;
      cur_busy = e[0];
      check("outs", 32'({tx_p, tx_n, tx_active, listen_window, listen_start, listen_done, busy}), 32'(e));
      check("overrun", 32'(overrun_cnt), 32'(exp_ovr));
      check("excl", 32'(tx_p & tx_n), 32'd0);
   endtask

   task automatic do_reset();
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      // 1: single triggered sequence and return to idle
      do_reset();
      for (int c = 0; c < 45; c++) cyc(c == 0, 1'b1, 1'b0);

      // 2: triggers while busy (mid-burst and last listen cycle) counted; restart at cycle 40
      do_reset();
      for (int c = 0; c < 85; c++) cyc(c == 0 || c == 10 || c == 39 || c == 40, 1'b1, 1'b0);

      // 3: disabled trigger ignored, then enable dropped mid-sequence
      do_reset();
      for (int c = 0; c < 6; c++) cyc(c == 0, 1'b0, 1'b0);
      for (int c = 0; c < 45; c++) cyc(c == 0, c < 5, 1'b0);

      // 4: reset mid-burst, then clean restart
      do_reset();
      for (int c = 0; c < 60; c++) cyc(c == 0 || c == 15, 1'b1, c == 12);

      // 5: continuous triggering saturates the overrun counter
      do_reset();
      for (int c = 0; c < 340; c++) cyc(1'b1, 1'b1, 1'b0);
      for (int c = 0; c < 45; c++) cyc(1'b0, 1'b1, 1'b0);
      check("ovr_sat", 32'(overrun_cnt), 32'd255);
      do_reset();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
